// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Requester 0 = main execute path, requester 1 = branch/address compare.
//   Round-robin arbitration, registered ALU operands, and a per-requester
//   response with a valid/ready handshake.
//   FSM: IDLE (grant) -> EXEC (ALU driven, 1 cycle) -> RESP (hold until ready).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready[1:0]   request handshake, bit i = requester i
//   reqN_in1/reqN_in2/reqN_op  requester N operands and ALU control code
//   alu_in1/alu_in2/alu_control  drive to the ALU (zero outside EXEC)
//   alu_result/alu_zero        combinational ALU outputs
//   rsp_valid/rsp_ready[1:0]   response handshake, bit i = requester i
//   rsp_data/rsp_zero/rsp_err  captured response
//
// Build option: ALU_ARB_OPCHK_EN -- when defined, op codes above 10 are
//   rejected at grant time: EXEC is skipped and the response carries
//   rsp_err=1 with zero data one cycle after the grant. When undefined,
//   every code goes through the ALU and rsp_err is always 0.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [WIDTH-1:0] req0_in2,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [WIDTH-1:0] req1_in2,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             id_q, last_q;
  logic [WIDTH-1:0] in1_q, in2_q, data_q;
  logic [OPW-1:0]   op_q;
  logic             zero_q, err_q;

  logic             gnt_vld, gnt_id, op_bad;
  logic [OPW-1:0]   gnt_op;

  // Grant selection: a lone requester wins; on a tie the one that did not
  // win last time wins. With neither valid gnt_id is don't-care.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_id  = (&req_valid) ? ~last_q : ~req_valid[0];
    gnt_op  = gnt_id ? req1_op : req0_op;
`ifdef ALU_ARB_OPCHK_EN
    op_bad  = (gnt_op > OPW'(10));
`else
    op_bad  = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = op_bad ? RESP : EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = '0;
    if (state_q == IDLE && gnt_vld && !reset) req_ready = 2'b01 << gnt_id;
    if (state_q == RESP)                      rsp_valid = 2'b01 << id_q;
    if (state_q == EXEC) begin
      alu_in1     = in1_q;
      alu_in2     = in2_q;
      alu_control = op_q;
    end
  end

  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;

  // Captured request and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
      id_q   <= 1'b0;
      in1_q  <= '0;
      in2_q  <= '0;
      op_q   <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_vld) begin
        id_q   <= gnt_id;
        last_q <= gnt_id;
        in1_q  <= gnt_id ? req1_in1 : req0_in1;
        in2_q  <= gnt_id ? req1_in2 : req0_in2;
        op_q   <= gnt_op;
        if (op_bad) begin
          // Rejected op: response is formed now, ALU never sees it.
          data_q <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        data_q <= alu_result;
        zero_q <= alu_zero;
        err_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0]  req0_in1, req0_in2, req1_in1, req1_in2;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  alu_in1, alu_in2, alu_result, rsp_data;
  logic [OW-1:0] alu_control;
  logic          alu_zero, rsp_zero, rsp_err;

  alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // External ALU: and/or/add/sub/slt; anything else gives result 0.
  always_comb begin
    case (alu_control)
      4'd0:    alu_result = alu_in1 & alu_in2;
      4'd1:    alu_result = alu_in1 | alu_in2;
      4'd2:    alu_result = alu_in1 + alu_in2;
      4'd6:    alu_result = alu_in1 - alu_in2;
      4'd8:    alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(logic id, logic [W-1:0] d, logic z, logic e);
    exp_t x;
    x.id = id; x.data = d; x.zero = z; x.err = e;
    return x;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops and checks one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (q.size() == 0) begin
            chk("rsp_unexpected", {31'd0, 1'b1}, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_id",   32'(i),        {31'd0, e.id});
            chk("rsp_data", rsp_data,      e.data);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
            chk("rsp_err",  {31'd0, rsp_err},  {31'd0, e.err});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(string name, logic [1:0] exp);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req_ready == 2'b00 && k < 20);
    chk(name, {30'd0, req_ready}, {30'd0, exp});
    step();
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    req0_in1 = '0; req0_in2 = '0; req0_op = '0;
    req1_in1 = '0; req1_in2 = '0; req1_op = '0;
    step(); step();
    @(negedge clk);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
    chk("rst_alu_ctl",   {28'd0, alu_control}, 32'd0);
    step(); reset = 1'b0;

    // 5 + 3: latency N / N+1 / N+2
    req0_in1 = 5; req0_in2 = 3; req0_op = 4'b0010; req_valid = 2'b01;
    q.push_back(mk(1'b0, 32'd8, 1'b0, 1'b0));
    @(negedge clk); chk("t1_ready_N", {30'd0, req_ready}, 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t1_alu_ctl_N1", {28'd0, alu_control}, 32'd2);
    chk("t1_alu_in1_N1", alu_in1, 32'd5);
    chk("t1_rsp_valid_N1", {30'd0, rsp_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("t1_rsp_valid_N2", {30'd0, rsp_valid}, 32'd1);
    chk("t1_alu_in1_resp", alu_in1, 32'd0);
    step(); drain();

    // Payload changes after acceptance are ignored
    step();
    req0_in1 = 5; req0_in2 = 3; req0_op = 4'b0010; req_valid = 2'b01;
    q.push_back(mk(1'b0, 32'd8, 1'b0, 1'b0));
    @(negedge clk); chk("t6_ready", {30'd0, req_ready}, 32'd1);
    step(); req_valid = 2'b00; req0_in1 = 100; req0_in2 = 100;
    @(negedge clk); chk("t6_alu_in1", alu_in1, 32'd5);
    step(); drain();

    // Op 1011 (unsupported)
    step();
    req0_in1 = 9; req0_in2 = 9; req0_op = 4'b1011; req_valid = 2'b01;
`ifdef ALU_ARB_OPCHK_EN
    q.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1));
    @(negedge clk); chk("t5_ready", {30'd0, req_ready}, 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t5_rsp_valid_N1", {30'd0, rsp_valid}, 32'd1);
    chk("t5_alu_ctl", {28'd0, alu_control}, 32'd0);
`else
    q.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0));
    @(negedge clk); chk("t5_ready", {30'd0, req_ready}, 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t5_rsp_valid_N1", {30'd0, rsp_valid}, 32'd0);
    chk("t5_alu_ctl", {28'd0, alu_control}, 32'd11);
    step();
    @(negedge clk); chk("t5_rsp_valid_N2", {30'd0, rsp_valid}, 32'd1);
`endif
    step(); drain();

    // Reset during EXEC of req1 (-1 < 1): response discarded
    step();
    req1_in1 = 32'hFFFF_FFFF; req1_in2 = 1; req1_op = 4'b1000; req_valid = 2'b10;
    @(negedge clk); chk("t4_ready", {30'd0, req_ready}, 32'd2);
    step(); req_valid = 2'b00;
    @(negedge clk); chk("t4_alu_ctl", {28'd0, alu_control}, 32'd8);
    reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t4_no_rsp", {30'd0, rsp_valid}, 32'd0);
      step();
    end

    // Both valid continuously: 0,1,0,1 starting with 0 after reset
    req0_in1 = 7; req0_in2 = 7; req0_op = 4'b0110;
    req1_in1 = 32'hF0; req1_in2 = 32'h0F; req1_op = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      q.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0));
      q.push_back(mk(1'b1, 32'hFF, 1'b0, 1'b0));
    end
    req_valid = 2'b11;
    wait_grant("t2_grant0", 2'b01);
    wait_grant("t2_grant1", 2'b10);
    wait_grant("t2_grant2", 2'b01);
    wait_grant("t2_grant3", 2'b10);
    req_valid = 2'b00;
    drain();

    // Backpressure: rsp_ready held off 5 cycles while req1 waits
    step();
    rsp_ready = 2'b10;  // non-owner bit must be ignored
    req0_in1 = 5; req0_in2 = 3; req0_op = 4'b0010; req_valid = 2'b01;
    q.push_back(mk(1'b0, 32'd8, 1'b0, 1'b0));
    @(negedge clk); chk("t3_ready0", {30'd0, req_ready}, 32'd1);
    step();
    req1_in1 = 9; req1_in2 = 9; req1_op = 4'b0110; req_valid = 2'b10;
    q.push_back(mk(1'b1, 32'd0, 1'b1, 1'b0));
    @(negedge clk); chk("t3_ready_exec", {30'd0, req_ready}, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {30'd0, rsp_valid}, 32'd1);
      chk("t3_hold_data",  rsp_data, 32'd8);
      chk("t3_hold_ready", {30'd0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    @(negedge clk); chk("t3_hs_valid", {30'd0, rsp_valid}, 32'd1);
    step();
    @(negedge clk); chk("t3_ready1_next", {30'd0, req_ready}, 32'd2);
    step(); req_valid = 2'b00;
    drain();

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
